// File: rtl/per_clk_gen.sv
// -----------------------------------------------------------------------------
// per_clk_gen
// Peripheral clock generator. Divides the system clock by a programmable
// ratio N (>= 2) and produces a registered divided clock together with
// single-cycle rise/fall strobes and a running count of peripheral periods.
// Everything lives in the system clock domain.
//
// Ports
//   clock      in   1   system clock, all registers update on its rising edge
//   reset      in   1   synchronous, active-low reset
//   div_wr     in   1   one-cycle request to load a new ratio
//   div_val    in  32   new ratio, sampled when div_wr=1 (values < 2 become 2)
//   clock_per  out  1   divided clock: N-floor(N/2) low cycles, floor(N/2) high
//   per_rise   out  1   strobe in the first high cycle of each period
//   per_fall   out  1   strobe in the first low cycle of each period
//                       (not in the first period after reset)
//   per_count  out 32   number of clock_per rising edges since reset (wraps)
//   div_cur    out 32   ratio currently in effect
//
// Parameter
//   clock_rate          ratio loaded at reset (clamped to at least 2)
// -----------------------------------------------------------------------------
module per_clk_gen #(
    parameter int unsigned clock_rate = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_wr,
    input  logic [31:0] div_val,
    output logic        clock_per,
    output logic        per_rise,
    output logic        per_fall,
    output logic [31:0] per_count,
    output logic [31:0] div_cur
);

    // Reset ratio, protected against a mis-set parameter below 2.
    localparam logic [31:0] RESET_DIV = (clock_rate < 2) ? 32'd2 : 32'(clock_rate);

    // Number of low cycles in a period of ratio n.
    function automatic logic [31:0] low_len(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

    // Any requested ratio below 2 is promoted to 2 so the output always toggles.
    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        logic [31:0] r;
        if (n < 32'd2) begin
            r = 32'd2;
        end else begin
            r = n;
        end
        return r;
    endfunction

    // cnt_q holds the phase that will be presented on clock_per after the
    // next edge; the outputs therefore lag the counter by one cycle, which
    // makes the first edge after reset present low phase 0.
    logic [31:0] cnt_q,       cnt_d;
    logic [31:0] div_q,       div_d;
    logic [31:0] pend_div_q,  pend_div_d;
    logic        pend_valid_q, pend_valid_d;
    logic        clock_per_q, clock_per_d;
    logic        per_rise_q,  per_rise_d;
    logic        per_fall_q,  per_fall_d;
    logic [31:0] per_count_q, per_count_d;

    logic [31:0] low_s;
    logic        last_s;

    // Next-state logic: phase counter, ratio hand-over and output decode.
    always_comb begin
        low_s        = low_len(div_q);
        last_s       = (cnt_q == (div_q - 32'd1));

        cnt_d        = cnt_q + 32'd1;
        div_d        = div_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;

        if (last_s) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        // A pending ratio only takes over at the period boundary, so the
        // period in progress always finishes with the old phases.
        if (last_s && pend_valid_q) begin
            div_d = pend_div_q;
        end else begin
            div_d = div_q;
        end

        // A write in the wrap cycle lands in the pending slot after the
        // hand-over above has consumed the previous one, so it waits for the
        // following boundary.
        if (div_wr) begin
            pend_div_d   = clamp_div(div_val);
            pend_valid_d = 1'b1;
        end else if (last_s && pend_valid_q) begin
            pend_div_d   = pend_div_q;
            pend_valid_d = 1'b0;
        end else begin
            pend_div_d   = pend_div_q;
            pend_valid_d = pend_valid_q;
        end

        clock_per_d = (cnt_q >= low_s);
        per_rise_d  = (cnt_q == low_s);
        // Phase 0 following a high cycle; right after reset clock_per_q is 0,
        // which suppresses the strobe in the first period.
        per_fall_d  = (cnt_q == 32'd0) && clock_per_q;

        if (per_rise_d) begin
            per_count_d = per_count_q + 32'd1;
        end else begin
            per_count_d = per_count_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q        <= 32'd0;
            div_q        <= RESET_DIV;
            pend_div_q   <= RESET_DIV;
            pend_valid_q <= 1'b0;
            clock_per_q  <= 1'b0;
            per_rise_q   <= 1'b0;
            per_fall_q   <= 1'b0;
            per_count_q  <= 32'd0;
        end else begin
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            clock_per_q  <= clock_per_d;
            per_rise_q   <= per_rise_d;
            per_fall_q   <= per_fall_d;
            per_count_q  <= per_count_d;
        end
    end

    assign clock_per = clock_per_q;
    assign per_rise  = per_rise_q;
    assign per_fall  = per_fall_q;
    assign per_count = per_count_q;
    assign div_cur   = div_q;

endmodule

// File: tb/tb_per_clk_gen.sv
module tb_per_clk_gen;

    localparam int unsigned RATE = 4;

    logic        clock;
    logic        reset;
    logic        div_wr;
    logic [31:0] div_val;
    logic        clock_per;
    logic        per_rise;
    logic        per_fall;
    logic [31:0] per_count;
    logic [31:0] div_cur;

    per_clk_gen #(.clock_rate(RATE)) dut (
        .clock     (clock),
        .reset     (reset),
        .div_wr    (div_wr),
        .div_val   (div_val),
        .clock_per (clock_per),
        .per_rise  (per_rise),
        .per_fall  (per_fall),
        .per_count (per_count),
        .div_cur   (div_cur)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        cp;
        logic        rise;
        logic        fall;
        logic [31:0] cnt;
        logic [31:0] div;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the waveform is a queue of upcoming clock_per samples,
    // refilled one whole period at a time from the ratio in effect.
    bit          samp_q[$];
    int unsigned m_div;
    int unsigned m_pend;
    bit          m_pend_v;
    bit          m_prev;
    logic [31:0] m_count;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fill(input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            samp_q.push_back(i >= int'(n - n / 2));
        end
    endtask

    // Model process: advances once per clock edge from the applied inputs.
    initial begin
        exp_t e;
        bit   s;
        bit   r;
        bit   f;
        forever begin
            @(posedge clock);
            if (!reset) begin
                m_div    = RATE;
                m_pend_v = 1'b0;
                samp_q.delete();
                fill(m_div);
                m_prev   = 1'b0;
                m_count  = 32'd0;
                e = '{cp: 1'b0, rise: 1'b0, fall: 1'b0, cnt: 32'd0, div: 32'(m_div)};
            end else begin
                if (samp_q.size() == 0) fill(m_div);
                s = samp_q.pop_front();
                r = s && !m_prev;
                f = !s && m_prev;
                m_prev = s;
                if (r) m_count = m_count + 32'd1;
                if (samp_q.size() == 0) begin
                    if (m_pend_v) begin
                        m_div    = m_pend;
                        m_pend_v = 1'b0;
                    end
                    fill(m_div);
                end
                if (div_wr) begin
                    m_pend   = (div_val < 32'd2) ? 2 : int'(div_val);
                    m_pend_v = 1'b1;
                end
                e = '{cp: s, rise: r, fall: f, cnt: m_count, div: 32'(m_div)};
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compares every presented output cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wave{cp,rise,fall}", {29'd0, clock_per, per_rise, per_fall},
                      {29'd0, e.cp, e.rise, e.fall});
                check("per_count", per_count, e.cnt);
                check("div_cur", div_cur, e.div);
            end
        end
    end

    task automatic cyc(input bit r, input bit w, input logic [31:0] v);
        @(negedge clock);
        #1;
        reset   = r;
        div_wr  = w;
        div_val = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'd0);
    endtask

    initial begin
        int  rises;
        bit  seen;
        reset   = 1'b0;
        div_wr  = 1'b0;
        div_val = 32'd0;

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'd0);

        // Ratio 4: ten periods after release.
        idle(40);
        @(negedge clock);
        check("count_after_10_periods", per_count, 32'd10);
        check("ratio4_div_cur", div_cur, 32'd4);

        // Load 8 one phase into a period; it takes effect at the wrap.
        idle(1);
        cyc(1'b1, 1'b1, 32'd8);
        idle(3);
        @(negedge clock);
        check("div_cur_after_load8", div_cur, 32'd8);
        idle(24);

        // Ratio 5 for a few periods.
        cyc(1'b1, 1'b1, 32'd5);
        idle(25);

        // Reset in high phase with a ratio of 6 pending.
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (per_rise) begin
                seen = 1'b1;
                break;
            end
        end
        check("rise_seen_before_reset", {31'd0, seen}, 32'd1);
        #1;
        reset   = 1'b1;
        div_wr  = 1'b1;
        div_val = 32'd6;
        cyc(1'b0, 1'b0, 32'd0);
        @(negedge clock);
        check("reset_clock_per", {31'd0, clock_per}, 32'd0);
        check("reset_per_count", per_count, 32'd0);
        check("reset_div_cur", div_cur, 32'(RATE));
        idle(12);
        @(negedge clock);
        check("pending6_dropped", div_cur, 32'(RATE));

        // Sub-2 ratios, last write wins.
        cyc(1'b1, 1'b1, 32'd1);
        cyc(1'b1, 1'b1, 32'd0);
        idle(12);
        @(negedge clock);
        check("div_cur_clamped", div_cur, 32'd2);

        // per_count wrap at 2^32.
        @(negedge clock);
        #1;
        force dut.per_count_q = 32'hFFFF_FFFE;
        m_count = 32'hFFFF_FFFE;
        #1;
        release dut.per_count_q;
        rises = 0;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (per_rise) rises++;
            if (rises == 2) begin
                seen = 1'b1;
                break;
            end
        end
        check("wrap_rises_seen", {31'd0, seen}, 32'd1);
        check("per_count_wrap", per_count, 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            bit          r;
            bit          w;
            logic [31:0] v;
            r = ($urandom_range(0, 499) != 0);
            w = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                v = 32'($urandom_range(0, 1));
            end else begin
                v = 32'($urandom_range(2, 9));
            end
            cyc(r, w, v);
        end

        idle(3);
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
